// File: rtl/seg_arb_pkg.sv
// seg_arb_pkg: shared state type and segment constants for the display arbiter.
package seg_arb_pkg;
   typedef enum logic [1:0] {IDLE, OWN, GAP} state_e;
   localparam int SEG_W = 7;
   localparam int DIGITS = 3;
   localparam logic [SEG_W-1:0] BLANK = 7'h7F;
endpackage

// File: rtl/seg_rr_picker.sv
// seg_rr_picker: one-hot round-robin pick of the first requester above the last owner.
module seg_rr_picker #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last,
   output logic [NUM_REQ-1:0]         pick,
   output logic                       valid
);
   // Scan from farthest to nearest so the nearest hit wins.
   always_comb begin
      pick = '0;
      for (int k = NUM_REQ; k >= 1; k--)
         if (req[(int'(last) + k) % NUM_REQ]) pick = NUM_REQ'(1) << ((int'(last) + k) % NUM_REQ);
      valid = |req;
   end
endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of a 3-digit seven-segment display with hold/lock preemption.
// SEG_ARB_BLANK_EN inserts a one-TickEn blank GAP on every owner switch.
module seg_display_arbiter
   import seg_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int HOLD_TICKS = 3
) (
   input  logic                            ClkIn,
   input  logic                            Rst_n,
   input  logic                            TickEn,
   input  logic [NUM_REQ-1:0]              Req,
   input  logic [NUM_REQ-1:0]              Lock,
   input  logic [NUM_REQ*SEG_W*DIGITS-1:0] SegData,
   input  logic [NUM_REQ-1:0]              DpIn,
   output logic [NUM_REQ-1:0]              Grant,
   output logic                            GrantValid,
   output logic [SEG_W-1:0]                SevenS0,
   output logic [SEG_W-1:0]                SevenS1,
   output logic [SEG_W-1:0]                SevenS2,
   output logic                            dec1
);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [3:0] HOLD = 4'(HOLD_TICKS);
   state_e state_q, state_d;
   logic [IW-1:0] owner_q, owner_d, pick_idx;
   logic [3:0] hold_q, hold_d;
   logic [DIGITS-1:0][SEG_W-1:0] seg_q, seg_d;
   logic dp_q, dp_d;
   logic [NUM_REQ-1:0] pick;
   logic pick_valid, release_own, preempt;

   // The current owner is masked out, so in OWN a valid pick means someone else waits.
   seg_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
      .req   (Req & ~Grant),
      .last  (owner_q),
      .pick  (pick),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pick[i]) pick_idx = IW'(i);
      release_own = state_q == OWN && !Req[owner_q];
      preempt = state_q == OWN && hold_q == HOLD && !Lock[owner_q] && pick_valid;
   end

   always_ff @(posedge ClkIn or negedge Rst_n)
      if (!Rst_n) begin
         state_q <= IDLE;
         owner_q <= IW'(NUM_REQ - 1);
         hold_q  <= '0;
         seg_q   <= {DIGITS{BLANK}};
         dp_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end

   // owner_q doubles as the round-robin pointer and survives IDLE/GAP.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: if (pick_valid) begin
            state_d = OWN;
            owner_d = pick_idx;
            hold_d  = '0;
         end
         OWN: if (release_own || preempt) begin
`ifdef SEG_ARB_BLANK_EN
            state_d = pick_valid ? GAP : IDLE;
`else
            state_d = pick_valid ? OWN : IDLE;
            owner_d = pick_valid ? pick_idx : owner_q;
            hold_d  = '0;
`endif
         end else if (TickEn && hold_q != HOLD) hold_d = hold_q + 4'd1;
         GAP: if (TickEn) begin
            state_d = pick_valid ? OWN : IDLE;
            owner_d = pick_valid ? pick_idx : owner_q;
            hold_d  = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Grant = '0;
      if (state_q == OWN) Grant[owner_q] = 1'b1;
      GrantValid = state_q == OWN;
      seg_d = state_q == OWN ? SegData[int'(owner_q)*SEG_W*DIGITS +: SEG_W*DIGITS] : {DIGITS{BLANK}};
      dp_d = state_q == OWN ? DpIn[owner_q] : 1'b1;
   end

   assign SevenS0 = seg_q[0];
   assign SevenS1 = seg_q[1];
   assign SevenS2 = seg_q[2];
   assign dec1    = dp_q;
endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the display (2..8).
REQ-002 SHALL have parameter HOLD_TICKS, default 3: minimum TickEn pulses an owner keeps the display before preemption (1..15).
REQ-003 SHALL have port ClkIn, input, 1: single clock; one clock only.
REQ-004 SHALL have port Rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port TickEn, input, 1: one-ClkIn-wide pacing strobe from the clock divider.
REQ-006 SHALL have port Req, input, NUM_REQ: per-requester display request, level.
REQ-007 SHALL have port Lock, input, NUM_REQ: owner asks to block preemption, level.
REQ-008 SHALL have port SegData, input, NUM_REQ*21: per requester 3 digits x 7 bits, active-low; requester i at [21i+20:21i], digit0 lowest.
REQ-009 SHALL have port DpIn, input, NUM_REQ: per-requester decimal point, active-low.
REQ-010 SHALL have port Grant, output, NUM_REQ: one-hot current owner, all-zero when none.
REQ-011 SHALL have port GrantValid, output, 1: high while any owner holds the display.
REQ-012 SHALL have ports SevenS0, SevenS1, SevenS2, output, 7 each: registered active-low segment drive.
REQ-013 SHALL have port dec1, output, 1: registered active-low decimal point.

Function
REQ-014 SHALL implement states IDLE, OWN (plus GAP per REQ-027).
REQ-015 IDLE: any Req bit high -> OWN; Grant asserts on the next ClkIn edge (1-cycle latency).
REQ-016 Selection SHALL be round-robin: first requesting index above the last owner, wrapping NUM_REQ-1 -> 0; after reset the search starts at index 0.
REQ-017 On entering OWN the hold counter SHALL clear to 0; a TickEn in the grant cycle is not counted.
REQ-018 In OWN each TickEn SHALL increment the hold counter, saturating at HOLD_TICKS.
REQ-019 Owner Req low SHALL release next cycle: -> next requester if any, else IDLE; this applies regardless of Lock or hold count.
REQ-020 Preemption SHALL occur only when hold counter == HOLD_TICKS, owner Lock low and another Req high; the owner is then replaced by the round-robin pick.
REQ-021 If no other requester is pending, the owner SHALL keep the display indefinitely.
REQ-022 If release and preemption conditions hold in the same cycle, release SHALL take precedence; the result is identical in target.
REQ-023 Segment outputs SHALL equal the owner's SegData slice and DpIn bit, registered one cycle after Grant; in IDLE they SHALL be 7'h7F and dec1 = 1.
REQ-024 Owner SegData changes SHALL reach the outputs with 1-cycle latency and no re-arbitration.
REQ-025 Grant SHALL never be multi-hot and never select an index with Req low for more than one cycle.

Reset
REQ-026 Rst_n low SHALL immediately force IDLE, Grant = 0, GrantValid = 0, SevenS0..2 = 7'h7F, dec1 = 1, hold counter = 0 and round-robin pointer = NUM_REQ-1, including mid-ownership.

Configuration
REQ-027 SEG_ARB_BLANK_EN defined: every owner change (OWN->OWN switch) SHALL pass through GAP for exactly one TickEn period, with outputs blank and Grant = 0, then grant the pick made on GAP exit. Undefined: switches are direct with no GAP state.

Structure
REQ-028 Package seg_arb_pkg SHALL hold the state enum, SEG_W = 7, DIGITS = 3, BLANK = 7'h7F.
REQ-029 Round-robin selection SHALL be a sub-module seg_rr_picker (inputs Req mask and last-owner index; outputs one-hot pick and valid).

Verification
REQ-030 Reset, Req = 4'b0100 -> Grant = 4'b0100 one cycle later; SevenS0..2 show requester 2 data one cycle after that.
REQ-031 Owner 0 and Req = 4'b0011, HOLD_TICKS = 3 -> Grant moves to 4'b0010 exactly after the 3rd TickEn, not before.
REQ-032 Owner 1 with Lock[1] = 1 and Req = 4'b1010 for 10 ticks -> Grant stays 4'b0010; Req[1] drop -> Grant = 4'b1000 next cycle.
REQ-033 Owner 3 and Req 3 drop with hold expired in the same cycle, Req = 4'b0001 -> Grant = 4'b0001 (wrap-around); Req all-zero -> IDLE, outputs 7'h7F.
REQ-034 Rst_n asserted mid-ownership between edges -> outputs blank, Grant = 0 without a clock edge.
REQ-035 With SEG_ARB_BLANK_EN defined, owner switch -> one TickEn period with Grant = 0 and outputs 7'h7F, then the new grant.
